// File: rtl/tiny_boot_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tiny_boot_loader
// Description : Holds the CPU in reset while a length-prefixed, checksummed
//               program image arrives on a valid/ready byte stream and is
//               written into RAM from LOAD_BASE. On a good checksum the CPU
//               is released and its memory port is passed straight to RAM.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tiny_boot_loader #(
    parameter logic [7:0] LOAD_BASE = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] cpu_adr,
    input  logic [7:0] cpu_writedata,
    input  logic       cpu_memwrite,
    output logic [7:0] ram_adr,
    output logic [7:0] ram_writedata,
    output logic       ram_memwrite,
    output logic       cpu_reset,
    output logic       boot_done,
    output logic       boot_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t     r_state;
    logic [8:0] r_count;      // number of data bytes expected (1..256)
    logic [8:0] r_index;      // data bytes received so far
    logic [7:0] r_sum;        // running 8-bit sum of data bytes
    logic [7:0] r_ram_adr;
    logic [7:0] r_ram_wdata;
    logic       r_ram_we;
    logic       r_cpu_reset;
    logic       r_boot_done;
    logic       r_boot_err;

    logic       w_xfer;
    logic [8:0] w_index_next;
    logic [8:0] w_header_count;

    // The stream is accepted in every state except DONE
    assign in_ready       = (r_state != S_DONE);
    assign w_xfer         = in_valid & in_ready;
    assign w_index_next   = r_index + 9'd1;
    // A header of zero encodes a full 256-byte image
    assign w_header_count = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};

    // Loader FSM: header capture, RAM writes, checksum verdict
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= 9'd0;
            r_index     <= 9'd0;
            r_sum       <= 8'h00;
            r_ram_adr   <= 8'h00;
            r_ram_wdata <= 8'h00;
            r_ram_we    <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_boot_done <= 1'b0;
            r_boot_err  <= 1'b0;
        end else begin
            r_ram_we <= 1'b0;
            case (r_state)
                S_IDLE, S_ERR: begin
                    if (w_xfer) begin
                        r_count    <= w_header_count;
                        r_index    <= 9'd0;
                        r_sum      <= 8'h00;
                        r_boot_err <= 1'b0;
                        r_state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_xfer) begin
                        r_ram_adr   <= LOAD_BASE + r_index[7:0];
                        r_ram_wdata <= in_data;
                        r_ram_we    <= 1'b1;
                        r_sum       <= r_sum + in_data;
                        r_index     <= w_index_next;
                        if (w_index_next == r_count) begin
                            r_state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (w_xfer) begin
                        if (in_data == r_sum) begin
                            r_state     <= S_DONE;
                            r_boot_done <= 1'b1;
                            r_cpu_reset <= 1'b0;
                        end else begin
                            r_state    <= S_ERR;
                            r_boot_err <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Once booted the CPU owns the RAM port directly; before that the loader does
    assign ram_adr       = (r_state == S_DONE) ? cpu_adr       : r_ram_adr;
    assign ram_writedata = (r_state == S_DONE) ? cpu_writedata : r_ram_wdata;
    assign ram_memwrite  = (r_state == S_DONE) ? cpu_memwrite  : r_ram_we;

    assign cpu_reset = r_cpu_reset;
    assign boot_done = r_boot_done;
    assign boot_err  = r_boot_err;

endmodule
`default_nettype wire

// File: tb/tb_tiny_boot_loader.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_tiny_boot_loader
// Description : Self-checking bench for tiny_boot_loader. Instance 0 uses
//               LOAD_BASE 00, instance 1 uses LOAD_BASE F0. Expected RAM
//               writes are queued when bytes are driven and checked by a
//               monitor when the write strobe appears.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_tiny_boot_loader;

    typedef struct packed {
        int         cyc;
        logic [7:0] adr;
        logic [7:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic [1:0] in_valid = 2'b00;
    logic [1:0] in_ready;
    logic [7:0] cpu_adr = 8'h00;
    logic [7:0] cpu_writedata = 8'h00;
    logic       cpu_memwrite = 1'b0;
    logic [7:0] ram_adr [2];
    logic [7:0] ram_wd [2];
    logic [1:0] ram_memwrite;
    logic [1:0] cpu_reset;
    logic [1:0] boot_done;
    logic [1:0] boot_err;

    int  errors = 0;
    int  checks = 0;
    int  cyc = 0;
    int  wr_count [2];
    wr_t sb [2][$];
    wr_t mon_e;

    tiny_boot_loader #(.LOAD_BASE(8'h00)) u_dut0 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .cpu_adr(cpu_adr), .cpu_writedata(cpu_writedata),
        .cpu_memwrite(cpu_memwrite), .ram_adr(ram_adr[0]), .ram_writedata(ram_wd[0]),
        .ram_memwrite(ram_memwrite[0]), .cpu_reset(cpu_reset[0]),
        .boot_done(boot_done[0]), .boot_err(boot_err[0])
    );

    tiny_boot_loader #(.LOAD_BASE(8'hF0)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .cpu_adr(cpu_adr), .cpu_writedata(cpu_writedata),
        .cpu_memwrite(cpu_memwrite), .ram_adr(ram_adr[1]), .ram_writedata(ram_wd[1]),
        .ram_memwrite(ram_memwrite[1]), .cpu_reset(cpu_reset[1]),
        .boot_done(boot_done[1]), .boot_err(boot_err[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: every loader write must match the oldest queued entry
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                if (ram_memwrite[i] && !boot_done[i]) begin
                    wr_count[i]++;
                    checks++;
                    if (sb[i].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_write inst=%0d adr=%h data=%h required no write",
                                 i, ram_adr[i], ram_wd[i]);
                    end else begin
                        mon_e = sb[i].pop_front();
                        if (ram_adr[i] !== mon_e.adr || ram_wd[i] !== mon_e.data || cyc !== mon_e.cyc) begin
                            errors++;
                            $display("FAIL ram_write inst=%0d got adr=%h data=%h cyc=%0d required adr=%h data=%h cyc=%0d",
                                     i, ram_adr[i], ram_wd[i], cyc, mon_e.adr, mon_e.data, mon_e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        in_valid = 2'b00;
        @(negedge clk);
        reset = 1'b0;
        wr_count[0] = 0;
        wr_count[1] = 0;
    endtask

    // Drive one byte; data bytes queue their expected write one cycle later
    task automatic send_byte(input int inst, input logic [7:0] b,
                             input bit is_data, input logic [7:0] adr);
        wr_t w;
        @(negedge clk);
        in_data        = b;
        in_valid       = 2'b00;
        in_valid[inst] = 1'b1;
        checks++;
        if (in_ready[inst] !== 1'b1) begin
            errors++;
            $display("FAIL in_ready inst=%0d byte=%h got %b required 1", inst, b, in_ready[inst]);
        end
        if (is_data) begin
            w.cyc  = cyc + 1;
            w.adr  = adr;
            w.data = b;
            sb[inst].push_back(w);
        end
        @(posedge clk);
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 2'b00;
        end
    endtask

    task automatic check_done(input int inst, input string name);
        checks++;
        if (boot_done[inst] !== 1'b1 || cpu_reset[inst] !== 1'b0 || boot_err[inst] !== 1'b0) begin
            errors++;
            $display("FAIL %s inst=%0d got done=%b cpu_reset=%b err=%b required 1 0 0",
                     name, inst, boot_done[inst], cpu_reset[inst], boot_err[inst]);
        end
    endtask

    task automatic check_empty(input int inst, input string name);
        checks++;
        if (sb[inst].size() != 0) begin
            errors++;
            $display("FAIL %s inst=%0d pending writes got %0d required 0", name, inst, sb[inst].size());
        end
    endtask

    task automatic test_reset();
        cpu_memwrite  = 1'b1;
        cpu_adr       = 8'h20;
        cpu_writedata = 8'h3C;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (in_ready[i] !== 1'b1 || cpu_reset[i] !== 1'b1 || boot_done[i] !== 1'b0 ||
                boot_err[i] !== 1'b0 || ram_memwrite[i] !== 1'b0 ||
                ram_adr[i] !== 8'h00 || ram_wd[i] !== 8'h00) begin
                errors++;
                $display("FAIL reset_state inst=%0d got rdy=%b cr=%b done=%b err=%b we=%b adr=%h wd=%h required 1 1 0 0 0 00 00",
                         i, in_ready[i], cpu_reset[i], boot_done[i], boot_err[i],
                         ram_memwrite[i], ram_adr[i], ram_wd[i]);
            end
        end
        cpu_memwrite = 1'b0;
    endtask

    task automatic test_good_and_passthrough();
        do_reset();
        cpu_memwrite  = 1'b1;
        cpu_adr       = 8'h20;
        cpu_writedata = 8'h3C;
        @(negedge clk);
        checks++;
        if (ram_memwrite[0] !== 1'b0 || ram_adr[0] !== 8'h00) begin
            errors++;
            $display("FAIL passthru_before_done got we=%b adr=%h required 0 00", ram_memwrite[0], ram_adr[0]);
        end
        send_byte(0, 8'h03, 1'b0, 8'h00);
        send_byte(0, 8'h80, 1'b1, 8'h00);
        send_byte(0, 8'h01, 1'b1, 8'h01);
        send_byte(0, 8'h7F, 1'b1, 8'h02);
        checks++;
        if (boot_done[0] !== 1'b0 || cpu_reset[0] !== 1'b1) begin
            errors++;
            $display("FAIL early_done got done=%b cpu_reset=%b required 0 1", boot_done[0], cpu_reset[0]);
        end
        send_byte(0, 8'h00, 1'b0, 8'h00);
        @(negedge clk);
        in_valid = 2'b00;
        check_done(0, "good_done");
        check_empty(0, "good_writes");
        checks++;
        if (wr_count[0] != 3) begin
            errors++;
            $display("FAIL good_write_count got %0d required 3", wr_count[0]);
        end
        checks++;
        if (in_ready[0] !== 1'b0 || ram_memwrite[0] !== 1'b1 || ram_adr[0] !== 8'h20 || ram_wd[0] !== 8'h3C) begin
            errors++;
            $display("FAIL passthru_after_done got rdy=%b we=%b adr=%h wd=%h required 0 1 20 3C",
                     in_ready[0], ram_memwrite[0], ram_adr[0], ram_wd[0]);
        end
        #1;
        cpu_adr      = 8'h21;
        cpu_memwrite = 1'b0;
        #1;
        checks++;
        if (ram_memwrite[0] !== 1'b0 || ram_adr[0] !== 8'h21) begin
            errors++;
            $display("FAIL passthru_comb got we=%b adr=%h required 0 21", ram_memwrite[0], ram_adr[0]);
        end
        // Stream bytes are ignored once booted
        @(negedge clk);
        in_data     = 8'hFF;
        in_valid[0] = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 2'b00;
        checks++;
        if (boot_done[0] !== 1'b1 || ram_memwrite[0] !== 1'b0 || in_ready[0] !== 1'b0) begin
            errors++;
            $display("FAIL done_sticky got done=%b we=%b rdy=%b required 1 0 0",
                     boot_done[0], ram_memwrite[0], in_ready[0]);
        end
    endtask

    task automatic test_bad_checksum();
        do_reset();
        send_byte(0, 8'h02, 1'b0, 8'h00);
        send_byte(0, 8'h10, 1'b1, 8'h00);
        send_byte(0, 8'h20, 1'b1, 8'h01);
        send_byte(0, 8'h05, 1'b0, 8'h00);
        @(negedge clk);
        in_valid = 2'b00;
        checks++;
        if (boot_err[0] !== 1'b1 || cpu_reset[0] !== 1'b1 || boot_done[0] !== 1'b0) begin
            errors++;
            $display("FAIL bad_err got err=%b cpu_reset=%b done=%b required 1 1 0",
                     boot_err[0], cpu_reset[0], boot_done[0]);
        end
        send_byte(0, 8'h01, 1'b0, 8'h00);
        gap(1);
        checks++;
        if (boot_err[0] !== 1'b0 || cpu_reset[0] !== 1'b1) begin
            errors++;
            $display("FAIL err_clear got err=%b cpu_reset=%b required 0 1", boot_err[0], cpu_reset[0]);
        end
        send_byte(0, 8'hAA, 1'b1, 8'h00);
        send_byte(0, 8'hAA, 1'b0, 8'h00);
        gap(1);
        check_done(0, "recover_done");
        check_empty(0, "recover_writes");
    endtask

    task automatic test_bubbles();
        do_reset();
        send_byte(0, 8'h03, 1'b0, 8'h00);
        gap(2);
        send_byte(0, 8'h11, 1'b1, 8'h00);
        gap(2);
        send_byte(0, 8'h22, 1'b1, 8'h01);
        gap(2);
        send_byte(0, 8'h33, 1'b1, 8'h02);
        gap(2);
        send_byte(0, 8'h66, 1'b0, 8'h00);
        gap(1);
        check_done(0, "bubble_done");
        check_empty(0, "bubble_writes");
        checks++;
        if (wr_count[0] != 3) begin
            errors++;
            $display("FAIL bubble_write_count got %0d required 3", wr_count[0]);
        end
    endtask

    task automatic test_reset_mid_load();
        do_reset();
        send_byte(0, 8'h04, 1'b0, 8'h00);
        send_byte(0, 8'hA1, 1'b1, 8'h00);
        send_byte(0, 8'hB2, 1'b1, 8'h01);
        @(negedge clk);
        in_valid = 2'b00;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (ram_memwrite[0] !== 1'b0 || cpu_reset[0] !== 1'b1 || boot_done[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid got we=%b cpu_reset=%b done=%b required 0 1 0",
                     ram_memwrite[0], cpu_reset[0], boot_done[0]);
        end
        @(negedge clk);
        reset = 1'b0;
        send_byte(0, 8'h01, 1'b0, 8'h00);
        send_byte(0, 8'h55, 1'b1, 8'h00);
        send_byte(0, 8'h55, 1'b0, 8'h00);
        gap(1);
        check_done(0, "reset_mid_done");
        check_empty(0, "reset_mid_writes");
    endtask

    task automatic test_full_wrap();
        logic [7:0] a;
        do_reset();
        send_byte(1, 8'h00, 1'b0, 8'h00);
        for (int i = 0; i < 256; i++) begin
            a = 8'hF0 + i[7:0];
            send_byte(1, i[7:0], 1'b1, a);
        end
        send_byte(1, 8'h80, 1'b0, 8'h00);
        gap(1);
        check_done(1, "full_done");
        check_empty(1, "full_writes");
        checks++;
        if (wr_count[1] != 256) begin
            errors++;
            $display("FAIL full_write_count got %0d required 256", wr_count[1]);
        end
    endtask

    initial begin
        wr_count[0] = 0;
        wr_count[1] = 0;
        test_reset();
        test_good_and_passthrough();
        test_bad_checksum();
        test_bubbles();
        test_reset_mid_load();
        test_full_wrap();
        gap(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
